ahb_lite_mem_slave: RTL and testbench
=====================================

AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words in the array.
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..7: HREADYOUT-low cycles inserted per OKAY transfer.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-004 HCLK  in  1  clock; all logic on rising edge.
REQ-005 HRESET  in  1  synchronous, active-high reset.
REQ-006 HSEL  in  1  slave select, decoded from HADDR.
REQ-007 HADDR  in  32  byte address (address phase).
REQ-008 HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 HWRITE  in  1  1=write, 0=read (address phase).
REQ-010 HSIZE  in  3  0=byte, 1=half, 2=word (address phase).
REQ-011 HBURST  in  3  burst type; accepted, not used for addressing.
REQ-012 HWDATA  in  32  write data (data phase).
REQ-013 HREADY  in  1  bus-level ready (HREADYIN).
REQ-014 HREADYOUT  out  1  transfer-complete / wait-state control.
REQ-015 HRDATA  out  32  read data, valid when HREADYOUT=1 ending a read.
REQ-016 HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-017 Address phase SHALL be accepted only when HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR/HWRITE/HSIZE SHALL then be registered.
REQ-018 HTRANS IDLE or BUSY, or HSEL=0, with HREADY=1 SHALL produce a zero-wait OKAY data phase with no memory access.
REQ-019 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-020 IDLE->WAIT on valid accepted transfer when WAIT_STATES>0; IDLE->DATA when WAIT_STATES=0; IDLE->ERR1 on illegal transfer.
REQ-021 WAIT: HREADYOUT=0, HRESP=0, down-counter loaded with WAIT_STATES; ->DATA when counter reaches 1.
REQ-022 DATA: HREADYOUT=1, HRESP=0; read data driven on HRDATA, write committed at end of cycle; accepts next address phase (pipelined) and branches per REQ-020, else ->IDLE.
REQ-023 Total OKAY data-phase length SHALL be exactly WAIT_STATES+1 cycles.
REQ-024 Illegal = HSIZE>2, HSIZE=1 with HADDR[0]=1, HSIZE=2 with HADDR[1:0]!=0, or (HADDR-BASE_ADDR)>>2 >= DEPTH or HADDR<BASE_ADDR.
REQ-025 ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1; ERR1->ERR2->(REQ-022 accept rule) ; no write SHALL occur.
REQ-026 Word index = (HADDR-BASE_ADDR)[log2(DEPTH)+1:2].
REQ-027 Write byte enables: byte -> 1 lane at HADDR[1:0]; half -> lanes {1,0} or {3,2} by HADDR[1]; word -> all 4; only enabled lanes of HWDATA updated.
REQ-028 Reads SHALL return the full 32-bit word regardless of HSIZE; HRDATA SHALL hold its last value outside read DATA cycles.
REQ-029 Write to address A followed immediately by read of A SHALL return the newly written data.
REQ-030 HBURST SHALL be ignored; each beat addressed solely by HADDR, including WRAP4/8 wrap points.

Reset
REQ-031 On HRESET=1 at a clock edge: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0.
REQ-032 Reset mid-transfer SHALL abort the transfer with no write committed; memory contents are not cleared.

Verification
REQ-033 WAIT_STATES=1: word write 32'hDEADBEEF @0x10, then read @0x10 -> HREADYOUT low 1 cycle each, HRDATA=32'hDEADBEEF, HRESP=0.
REQ-034 Word 0x11223344 @0x20, byte write 0xAA @0x22, half write 0x5566 @0x20 -> read returns 32'h11AA5566.
REQ-035 Word read @0x02 -> ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (HREADYOUT=1,HRESP=1); address (DEPTH*4) read -> same two-cycle ERROR.
REQ-036 WAIT_STATES=0, INCR8 read 0x40..0x5C with BUSY inserted after beat 3 -> 8 beats, one per cycle, BUSY gets zero-wait OKAY, data matches preloaded words.
REQ-037 HRESET asserted during WAIT of a write to 0x30 -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; later read of 0x30 returns pre-reset contents.

Source files
------------

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-organised memory slave with configurable wait states, byte-lane
// writes, pipelined address acceptance and a two-cycle ERROR response.
module ahb_lite_mem_slave #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t          state;
  logic [2:0]      wait_cnt;
  logic            a_write;
  logic [1:0]      a_size;
  logic [1:0]      a_lane;
  logic [AW-1:0]   a_idx;

  logic [31:0]     mem [DEPTH];

  logic [31:0]     offset;
  logic [AW-1:0]   next_idx;
  logic            accept;
  logic            illegal;
  logic [3:0]      wr_be;
  logic            wr_en;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_word;
  logic            unused_bits;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    lane_mask = 4'b0001 << lane;
      2'd1:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign offset   = HADDR - BASE_ADDR;
  assign next_idx = offset[AW+1:2];
  assign accept   = HSEL && HREADY && HTRANS[1];
  assign illegal  = (HSIZE > 3'd2)
                 || ((HSIZE == 3'd1) && HADDR[0])
                 || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                 || (HADDR < BASE_ADDR)
                 || ({2'b00, offset[31:2]} >= DEPTH);

  // HBURST is accepted but never steers addressing; each beat uses HADDR alone.
  assign unused_bits = ^{HBURST, HTRANS[0], offset[1:0]};

  assign wr_be  = lane_mask(a_size, a_lane);
  assign wr_en  = (state == ST_DATA) && a_write && !HRESET;
  assign rd_idx = (state == ST_WAIT) ? a_idx : next_idx;

  // With zero wait states a read can be accepted during the data phase of a
  // write to the same word, so the pending lanes are forwarded into the read.
  always_comb begin
    // NOTE: rd_word takes its default before any conditional update, so no latch is inferred.
    rd_word = mem[rd_idx];
    if (wr_en && (a_idx == rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto RAM; reset only aborts a pending write.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[a_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'h0;
      wait_cnt  <= 3'd0;
      a_write   <= 1'b0;
      a_size    <= 2'd0;
      a_lane    <= 2'd0;
      a_idx     <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt <= 3'd1) begin
            state     <= ST_DATA;
            HREADYOUT <= 1'b1;
            wait_cnt  <= 3'd0;
            if (!a_write) HRDATA <= rd_word;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          if (accept) begin
            a_write <= HWRITE;
            a_size  <= HSIZE[1:0];
            a_lane  <= HADDR[1:0];
            a_idx   <= next_idx;
            if (illegal) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state     <= ST_DATA;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              if (!HWRITE) HRDATA <= rd_word;
            end else begin
              state     <= ST_WAIT;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
              wait_cnt  <= 3'(WAIT_STATES);
            end
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench: dut0 runs with zero wait states, dut1 with one; both are
// driven as a single-master bus with HREADY looped back from HREADYOUT.
module tb_ahb_lite_mem_slave;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic [31:0] hrdata    [2];
  logic        hresp     [2];

  int n_pass   = 0;
  int n_checks = 0;

  logic [7:0] model_bytes [2][1024];

  always #5 clk = ~clk;

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_lite_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
    .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0])
  );

  ahb_lite_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
    .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1])
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_resp;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte-addressed reference memory: a transfer of 2**size bytes at addr,
  // each byte taken from the HWDATA lane matching its own address.
  task automatic model_write(input int w, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] data);
    for (int k = 0; k < (1 << size); k++) begin
      logic [31:0] a;
      a = addr + 32'(k);
      model_bytes[w][a[9:0]] = data[8*a[1:0] +: 8];
    end
  endtask

  function automatic logic [31:0] model_word(input int w, input logic [31:0] addr);
    logic [9:0] b;
    b = {addr[9:2], 2'b00};
    return {model_bytes[w][b + 10'd3], model_bytes[w][b + 10'd2],
            model_bytes[w][b + 10'd1], model_bytes[w][b]};
  endfunction

  function automatic bit model_illegal(input logic [31:0] addr, input logic [2:0] size);
    if (size > 3'd2) return 1'b1;
    if ((addr % (32'd1 << size)) != 0) return 1'b1;
    return (addr >= 32'(DEPTH * 4));
  endfunction

  function automatic int ws_of(input int w);
    return (w == 1) ? 1 : 0;
  endfunction

  // Single non-pipelined transfer: address phase, then data phase until HREADYOUT.
  task automatic xfer(input int w, input string nm, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata, input logic [2:0] burst,
                      input logic exp_resp, input int exp_waits, input logic chk_rd,
                      input logic [31:0] exp_rd);
    int   waits;
    logic first_resp;
    hsel[w] = 1'b1; htrans[w] = 2'b10; haddr[w] = addr; hwrite[w] = wr;
    hsize[w] = size; hburst[w] = burst;
    tick();
    hsel[w] = 1'b0; htrans[w] = 2'b00; hwdata[w] = wdata;
    first_resp = hresp[w];
    waits = 0;
    while (!hreadyout[w] && waits < 32) begin
      waits++;
      tick();
    end
    check({nm, " ready"}, 32'(hreadyout[w]), 32'd1);
    check({nm, " waits"}, 32'(waits), 32'(exp_waits));
    check({nm, " first resp"}, 32'(first_resp), 32'(exp_resp));
    check({nm, " resp"}, 32'(hresp[w]), 32'(exp_resp));
    if (chk_rd && !exp_resp) check({nm, " rdata"}, hrdata[w], exp_rd);
    tick();
  endtask

  task automatic do_write(input int w, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data);
    model_write(w, addr, size, data);
    xfer(w, "preload", 1'b1, addr, size, data, 3'd0, 1'b0, ws_of(w), 1'b0, 32'h0);
  endtask

  // Write immediately followed (pipelined) by a word read of the same word.
  task automatic wr_then_rd(input int w, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data);
    logic [31:0] exp;
    int guard;
    model_write(w, addr, size, data);
    exp = model_word(w, addr);
    hsel[w] = 1'b1; htrans[w] = 2'b10; haddr[w] = addr; hwrite[w] = 1'b1;
    hsize[w] = size; hburst[w] = 3'd0;
    tick();
    hwdata[w] = data; haddr[w] = {addr[31:2], 2'b00}; hwrite[w] = 1'b0; hsize[w] = 3'd2;
    guard = 0;
    while (!hreadyout[w] && guard < 32) begin guard++; tick(); end
    tick();
    hsel[w] = 1'b0; htrans[w] = 2'b00;
    guard = 0;
    while (!hreadyout[w] && guard < 32) begin guard++; tick(); end
    check($sformatf("wr->rd dut%0d ready", w), 32'(hreadyout[w]), 32'd1);
    check($sformatf("wr->rd dut%0d @%h", w, addr), hrdata[w], exp);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ph_t [10];
    logic [31:0] ph_a [10];
    for (int w = 0; w < 2; w++) begin
      hsel[w] = 1'b0; haddr[w] = 32'h0; htrans[w] = 2'b00; hwrite[w] = 1'b0;
      hsize[w] = 3'd0; hburst[w] = 3'd0; hwdata[w] = 32'h0;
    end
    rst = 1'b1;
    tick(); tick();
    for (int w = 0; w < 2; w++) begin
      check($sformatf("reset dut%0d hreadyout", w), 32'(hreadyout[w]), 32'd1);
      check($sformatf("reset dut%0d hresp", w), 32'(hresp[w]), 32'd0);
      check($sformatf("reset dut%0d hrdata", w), hrdata[w], 32'h0);
    end
    rst = 1'b0;
    tick();

    // Directed vectors on the one-wait-state instance.
    vecs[0]  = '{1'b1, 32'h010, 3'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h010, 3'd2, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h020, 3'd2, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h022, 3'd0, 32'h77AA_9988, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h020, 3'd1, 32'hCCDD_5566, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h020, 3'd2, 32'h0,         1'b0, 1'b1, 32'h11AA_5566};
    vecs[6]  = '{1'b0, 32'h023, 3'd0, 32'h0,         1'b0, 1'b1, 32'h11AA_5566};
    vecs[7]  = '{1'b0, 32'h002, 3'd2, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h400, 3'd2, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h000, 3'd2, 32'h0102_0304, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h002, 3'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h001, 3'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'h000, 3'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h000, 3'd2, 32'h0,         1'b0, 1'b1, 32'h0102_0304};
    vecs[14] = '{1'b1, 32'h3FC, 3'd2, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h3FC, 3'd2, 32'h0,         1'b0, 1'b1, 32'hA5A5_5A5A};
    vecs[16] = '{1'b1, 32'h012, 3'd1, 32'h1234_0000, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'h010, 3'd2, 32'h0,         1'b0, 1'b1, 32'h1234_BEEF};
    vecs[18] = '{1'b0, 32'h3FD, 3'd0, 32'h0,         1'b0, 1'b1, 32'hA5A5_5A5A};
    vecs[19] = '{1'b1, 32'h400, 3'd2, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0};
    vecs[20] = '{1'b0, 32'hFFFF_FFFC, 3'd2, 32'h0,   1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 21; i++) begin
      xfer(1, $sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
           3'd0, vecs[i].exp_resp, 1, vecs[i].chk_rd, vecs[i].exp_rd);
    end

    // Reset during the wait state of a write aborts it; memory keeps old contents.
    do_write(1, 32'h30, 3'd2, 32'hCAFE_F00D);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h30; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    tick();
    check("abort in wait", 32'(hreadyout[1]), 32'd0);
    rst = 1'b1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h1234_5678;
    tick();
    check("abort hreadyout", 32'(hreadyout[1]), 32'd1);
    check("abort hresp", 32'(hresp[1]), 32'd0);
    check("abort hrdata", hrdata[1], 32'h0);
    rst = 1'b0;
    tick();
    xfer(1, "post-abort read", 1'b0, 32'h30, 3'd2, 32'h0, 3'd0, 1'b0, 1, 1'b1, 32'hCAFE_F00D);

    // Back-to-back write then read of the same word, including partial lanes.
    for (int w = 0; w < 2; w++) begin
      wr_then_rd(w, 32'h60, 3'd2, 32'h0BAD_F00D);
      wr_then_rd(w, 32'h62, 3'd1, 32'hFACE_0000);
      wr_then_rd(w, 32'h61, 3'd0, 32'h0000_3C00);
    end

    // INCR8 read burst with a BUSY after the fourth beat, zero wait states.
    for (int i = 0; i < 8; i++) do_write(0, 32'h40 + 32'(4 * i), 3'd2, 32'hB000_0000 + 32'(i) * 32'h0101_0101);
    for (int p = 0; p < 10; p++) begin
      ph_t[p] = 2'b11;
      ph_a[p] = 32'h40 + 32'(4 * ((p > 4) ? p - 1 : p));
    end
    ph_t[0] = 2'b10;
    ph_t[4] = 2'b01;
    ph_t[9] = 2'b00;
    for (int p = 0; p < 10; p++) begin
      hsel[0] = 1'b1; htrans[0] = ph_t[p]; haddr[0] = ph_a[p]; hwrite[0] = 1'b0;
      hsize[0] = 3'd2; hburst[0] = 3'b101;
      tick();
      check($sformatf("burst p%0d ready", p), 32'(hreadyout[0]), 32'd1);
      check($sformatf("burst p%0d resp", p), 32'(hresp[0]), 32'd0);
      if (ph_t[p][1]) check($sformatf("burst p%0d data", p), hrdata[0], model_word(0, ph_a[p]));
    end
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    tick();

    // Randomised transfers against the byte-level reference model.
    for (int w = 0; w < 2; w++) begin
      for (int a = 32'h100; a < 32'h200; a += 4) do_write(w, 32'(a), 3'd2, $urandom);
      for (int n = 0; n < 100; n++) begin
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic        wr;
        if ($urandom_range(0, 9) == 0) addr = 32'h400 + 32'($urandom_range(0, 255));
        else addr = 32'h100 + 32'($urandom_range(0, 255));
        size  = 3'($urandom_range(0, 3));
        burst = 3'($urandom_range(0, 7));
        wr    = 1'($urandom_range(0, 1));
        data  = $urandom;
        if (model_illegal(addr, size)) begin
          xfer(w, $sformatf("rnd%0d err @%h", w, addr), wr, addr, size, data, burst,
               1'b1, 1, 1'b0, 32'h0);
        end else if (wr) begin
          model_write(w, addr, size, data);
          xfer(w, $sformatf("rnd%0d wr @%h", w, addr), 1'b1, addr, size, data, burst,
               1'b0, ws_of(w), 1'b0, 32'h0);
        end else begin
          xfer(w, $sformatf("rnd%0d rd @%h", w, addr), 1'b0, addr, size, 32'h0, burst,
               1'b0, ws_of(w), 1'b1, model_word(w, addr));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
